// File: rtl/multicycle_carry_skip_adder_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_carry_skip_adder_pkg
// Shared definitions for the multicycle carry-skip adder block:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - idx_width(): clog2-style helper that never returns less than 1, used to
//     size the slice index register
// No ports (package).
// ---------------------------------------------------------------------------
package multicycle_carry_skip_adder_pkg;

   typedef enum logic [1:0] {
      MCSA_IDLE = 2'd0,
      MCSA_RUN  = 2'd1,
      MCSA_DONE = 2'd2
   } mcsa_state_t;

   // max(1, ceil(log2(n))): a single-slice build still needs a 1-bit index
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((32'sd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/multicycle_carry_skip_adder_if.sv
// ---------------------------------------------------------------------------
// multicycle_carry_skip_adder_if
// Operand/result handshake bundle for multicycle_carry_skip_adder.
// Optional overflow flag exists only when MCSA_OVERFLOW_EN is defined.
// Signals:
//   in_valid  operands present            (master -> slave)
//   in_ready  slave accepts this cycle     (slave  -> master)
//   a, b      WIDTH-bit operands           (master -> slave)
//   carry_in  carry into bit 0             (master -> slave)
//   out_valid result valid                 (slave  -> master)
//   out_ready consumer takes result        (master -> slave)
//   sum       a + b + carry_in, low WIDTH  (slave  -> master)
//   carry_out carry out of bit WIDTH-1     (slave  -> master)
//   p         every bit propagates         (slave  -> master)
//   overflow  signed overflow (optional)   (slave  -> master)
// Modports: master (operand source / result consumer), slave (adder).
// ---------------------------------------------------------------------------
interface multicycle_carry_skip_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             p;
`ifdef MCSA_OVERFLOW_EN
   logic             overflow;
`endif

   modport master (
      output in_valid, a, b, carry_in, out_ready,
      input  in_ready, out_valid, sum, carry_out, p
`ifdef MCSA_OVERFLOW_EN
      , input overflow
`endif
   );

   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
      output in_ready, out_valid, sum, carry_out, p
`ifdef MCSA_OVERFLOW_EN
      , output overflow
`endif
   );

endinterface

// File: rtl/multicycle_carry_skip_adder_csa.sv
// ---------------------------------------------------------------------------
// carry_skip_adder
// Purely combinational WIDTH-bit carry-skip adder. Bits ripple inside blocks
// of BLOCK bits; when a whole block propagates, its carry-in bypasses the
// ripple chain straight to the next block.
// Optional output c_msb (MCSA_OVERFLOW_EN): carry into bit WIDTH-1, used by
// the parent to derive signed overflow.
// Ports:
//   a, b   in  WIDTH  operands
//   cin    in  1      carry into bit 0
//   sum    out WIDTH  a + b + cin, low WIDTH bits
//   cout   out 1      carry out of bit WIDTH-1
//   p      out 1      1 iff a ^ b is all ones
//   c_msb  out 1      carry into bit WIDTH-1 (MCSA_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module carry_skip_adder #(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             p
`ifdef MCSA_OVERFLOW_EN
   ,
   output logic             c_msb
`endif
);

   // Ripple within each block, skip mux at every block boundary
   always_comb begin
      logic carry_v;
      logic blk_in_v;
      logic blk_p_v;
      logic prop_v;
      logic blk_end_v;
      sum      = {WIDTH{1'b0}};
      p        = 1'b1;
      carry_v  = cin;
      blk_in_v = cin;
      blk_p_v  = 1'b1;
      prop_v   = 1'b0;
      blk_end_v = 1'b0;
`ifdef MCSA_OVERFLOW_EN
      c_msb    = 1'b0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
         prop_v = a[i] ^ b[i];
         sum[i] = prop_v ^ carry_v;
`ifdef MCSA_OVERFLOW_EN
         c_msb  = (i == WIDTH - 1) ? carry_v : c_msb;
`endif
         carry_v   = (a[i] & b[i]) | (prop_v & carry_v);
         blk_p_v   = blk_p_v & prop_v;
         p         = p & prop_v;
         blk_end_v = ((i % BLOCK) == (BLOCK - 1)) || (i == WIDTH - 1);
         // Fully propagating block: carry-out is just the block's carry-in
         carry_v   = (blk_end_v && blk_p_v) ? blk_in_v : carry_v;
         blk_in_v  = blk_end_v ? carry_v : blk_in_v;
         blk_p_v   = blk_end_v ? 1'b1 : blk_p_v;
      end
      cout = carry_v;
   end

endmodule

// File: rtl/multicycle_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// multicycle_carry_skip_adder
// Area-lean wide adder: WIDTH-bit operands are added CHUNK bits per clock
// through a single shared carry_skip_adder, with the inter-slice carry held
// in a register. Result latency is NUM_CHUNKS cycles after accept; with the
// consumer always ready, one result is produced every NUM_CHUNKS+1 cycles.
// Build option MCSA_OVERFLOW_EN adds the signed overflow output.
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   asynchronous reset, active-high
//   bus  slave modport of multicycle_carry_skip_adder_if
//        (in_valid/in_ready/a/b/carry_in in, out_valid/out_ready/sum/
//         carry_out/p[/overflow] out)
// ---------------------------------------------------------------------------
module multicycle_carry_skip_adder
   import multicycle_carry_skip_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   multicycle_carry_skip_adder_if.slave  bus
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_width_check
      $error("multicycle_carry_skip_adder: WIDTH must be a multiple of CHUNK");
   end

   mcsa_state_t      state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic [IDX_W-1:0] idx_r;
   logic             carry_r;
   logic             p_acc_r;
   logic             out_valid_r;
   logic             carry_out_r;
   logic             p_r;
`ifdef MCSA_OVERFLOW_EN
   logic             overflow_r;
   logic             slice_c_msb_s;
`endif

   logic             accept_s;
   logic [CHUNK-1:0] slice_a_s;
   logic [CHUNK-1:0] slice_b_s;
   logic [CHUNK-1:0] slice_sum_s;
   logic             slice_cout_s;
   logic             slice_p_s;

   // In DONE the consumer retiring the result frees the block on the same edge
   assign bus.in_ready = (state_r == MCSA_IDLE) ||
                         ((state_r == MCSA_DONE) && bus.out_ready);
   assign accept_s     = bus.in_valid && bus.in_ready;

   assign slice_a_s = a_r[int'(idx_r) * CHUNK +: CHUNK];
   assign slice_b_s = b_r[int'(idx_r) * CHUNK +: CHUNK];

   carry_skip_adder #(
      .WIDTH (CHUNK)
   ) u_csa (
      .a     (slice_a_s),
      .b     (slice_b_s),
      .cin   (carry_r),
      .sum   (slice_sum_s),
      .cout  (slice_cout_s),
      .p     (slice_p_s)
`ifdef MCSA_OVERFLOW_EN
      ,
      .c_msb (slice_c_msb_s)
`endif
   );

   // FSM plus operand latch, slice-by-slice sum and registered result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= MCSA_IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         sum_r       <= {WIDTH{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         carry_r     <= 1'b0;
         p_acc_r     <= 1'b0;
         out_valid_r <= 1'b0;
         carry_out_r <= 1'b0;
         p_r         <= 1'b0;
`ifdef MCSA_OVERFLOW_EN
         overflow_r  <= 1'b0;
`endif
      end else begin
         // Accept only happens in IDLE or DONE, never while RUN owns carry_r
         if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.carry_in;
            p_acc_r <= 1'b1;
            idx_r   <= {IDX_W{1'b0}};
         end
         case (state_r)
            MCSA_IDLE: begin
               if (accept_s) begin
                  state_r <= MCSA_RUN;
               end
            end
            MCSA_RUN: begin
               sum_r[int'(idx_r) * CHUNK +: CHUNK] <= slice_sum_s;
               carry_r <= slice_cout_s;
               p_acc_r <= p_acc_r & slice_p_s;
               if (idx_r == LAST_IDX) begin
                  carry_out_r <= slice_cout_s;
                  p_r         <= p_acc_r & slice_p_s;
`ifdef MCSA_OVERFLOW_EN
                  overflow_r  <= slice_c_msb_s ^ slice_cout_s;
`endif
                  out_valid_r <= 1'b1;
                  state_r     <= MCSA_DONE;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            MCSA_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= accept_s ? MCSA_RUN : MCSA_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= MCSA_IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.carry_out = carry_out_r;
   assign bus.p         = p_r;
`ifdef MCSA_OVERFLOW_EN
   assign bus.overflow  = overflow_r;
`endif

endmodule

// File: tb/tb_multicycle_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// tb_multicycle_carry_skip_adder
// Self-checking bench for multicycle_carry_skip_adder (WIDTH=32, CHUNK=8).
// Expected results come from a bench-side arithmetic model, are queued when
// operands are accepted and compared when the DUT hands a result over.
// ---------------------------------------------------------------------------
module tb_multicycle_carry_skip_adder;

   localparam int WIDTH      = 32;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = WIDTH / CHUNK;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry_out;
      logic             p;
      logic             overflow;
   } exp_t;

   logic  clk;
   logic  rst;
   int    tests_run;
   int    tests_failed;
   time   accept_time;
   exp_t  exp_q[$];
   exp_t  mon_e;

   multicycle_carry_skip_adder_if #(.WIDTH(WIDTH)) bus ();

   multicycle_carry_skip_adder #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if observed differs from required
   task automatic check_value(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] req);
      tests_run++;
      if (obs !== req) begin
         tests_failed++;
         $display("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   // Reference arithmetic for one operation
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin);
      logic [WIDTH:0] full;
      exp_t e;
      full        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.sum       = full[WIDTH-1:0];
      e.carry_out = full[WIDTH];
      e.p         = &(a ^ b);
      e.overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   // Present operands at a falling edge, hold until accepted; returns at the
   // falling edge following the accepting rising edge with in_valid dropped
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin);
      int n;
      n = 0;
      bus.a        = a;
      bus.b        = b;
      bus.carry_in = cin;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         check_value("send_timeout", 32'(n), 32'd0);
      end else begin
         exp_q.push_back(model(a, b, cin));
         @(posedge clk);
         accept_time = $time;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_value("wait_valid", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_value("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: compare every result retired by the consumer
   always @(negedge clk) begin
      #1;
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_value("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_value("sum", bus.sum, mon_e.sum);
            check_value("carry_out", 32'(bus.carry_out), 32'(mon_e.carry_out));
            check_value("p", 32'(bus.p), 32'(mon_e.p));
`ifdef MCSA_OVERFLOW_EN
            check_value("overflow", 32'(bus.overflow), 32'(mon_e.overflow));
`endif
         end
      end
   end

   initial begin
      time t0;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = 32'h0;
      bus.b         = 32'h0;
      bus.carry_in  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_value("rst_sum", bus.sum, 32'h0);
      check_value("rst_carry_out", 32'(bus.carry_out), 32'd0);
      check_value("rst_p", 32'(bus.p), 32'd0);
`ifdef MCSA_OVERFLOW_EN
      check_value("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check_value("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

      // All-propagate operand with carry_in: latency of NUM_CHUNKS cycles
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      check_value("latency_0", 32'(bus.out_valid), 32'd0);
      for (int i = 1; i <= NUM_CHUNKS; i++) begin
         @(negedge clk);
         check_value("latency", 32'(bus.out_valid), (i == NUM_CHUNKS) ? 32'd1 : 32'd0);
      end
      check_value("t1_sum", bus.sum, 32'h0000_0000);
      check_value("t1_carry_out", 32'(bus.carry_out), 32'd1);
      check_value("t1_p", 32'(bus.p), 32'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_value("t1_retired", 32'(bus.out_valid), 32'd0);

      // Result held while consumer stalls for 3 cycles, retired on the 4th
      send(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         check_value("hold_sum", bus.sum, 32'h2345_6789);
         check_value("hold_carry_out", 32'(bus.carry_out), 32'd0);
         check_value("hold_p", 32'(bus.p), 32'd0);
         check_value("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check_value("hold_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_value("t2_retired", 32'(bus.out_valid), 32'd0);

      // Back-to-back with consumer always ready: accept every NUM_CHUNKS+1 cycles
      bus.out_ready = 1'b1;
      send(32'h0000_00FF, 32'h0000_0001, 1'b0);
      t0 = accept_time;
      send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      check_value("b2b_gap_1", 32'((accept_time - t0) / 10), 32'(NUM_CHUNKS + 1));
      t0 = accept_time;
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      check_value("b2b_gap_2", 32'((accept_time - t0) / 10), 32'(NUM_CHUNKS + 1));
      drain();

      // Reset while RUN is at slice index 2: partial sum must vanish at once
      send(32'h0101_0101, 32'h0101_0101, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_value("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_value("midrun_rst_sum", bus.sum, 32'h0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_value("midrun_in_ready", 32'(bus.in_ready), 32'd1);
      send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
      drain();

      // Boundary operands (signed overflow, full carry chains) plus random ones
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      send(32'h00FF_00FF, 32'h0001_FF01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ra = 32'($urandom);
         rb = 32'($urandom);
         send(ra, rb, 1'($urandom_range(0, 1)));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
